// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch/execute/writeback sequencer for the NPC core; halts on ebreak.
// Optional PERF_CNT_EN macro adds perf_cycle / perf_instret counters.
module core_seq_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              if_req_valid,
    input  logic              if_req_ready,
    output logic [ADDR_W-1:0] if_req_addr,
    input  logic              if_resp_valid,
    input  logic [INST_W-1:0] if_resp_inst,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] pc,
    input  logic              dec_is_ebreak,
    output logic              ex_en,
    output logic              rf_wen,
    output logic              halt,
    input  logic [31:0]       halt_code,
    output logic              halt_good
`ifdef PERF_CNT_EN
    ,
    output logic [63:0]       perf_cycle,
    output logic [63:0]       perf_instret
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        EXEC  = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        if_req_valid = 1'b0;
        ex_en        = 1'b0;
        rf_wen       = 1'b0;
        halt         = 1'b0;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if_req_valid = 1'b1;
                if (if_req_ready) state_d = WAIT;
            end
            // a response only counts once the request has been accepted
            WAIT:  if (if_resp_valid) state_d = EXEC;
            EXEC: begin
                ex_en   = 1'b1;
                state_d = dec_is_ebreak ? HALT : WB;
            end
            WB: begin
                rf_wen  = 1'b1;
                state_d = FETCH;
            end
            HALT:  halt = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign if_req_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            inst      <= '0;
            halt_good <= 1'b0;
        end else begin
            if (state_q == WAIT && if_resp_valid) inst <= if_resp_inst;
            if (state_q == WB) pc <= pc + ADDR_W'(4);
            if (state_q == EXEC && dec_is_ebreak) halt_good <= (halt_code == 32'd0);
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycle   <= '0;
            perf_instret <= '0;
        end else begin
            if (state_q != IDLE && state_q != HALT) perf_cycle <= perf_cycle + 64'd1;
            if (state_q == WB) perf_instret <= perf_instret + 64'd1;
        end
    end
`endif

endmodule
